// File: rtl/fetch_stage.sv
// Instruction-fetch stage: sequential PC generation, one-cycle-latency SRAM reads,
// and a 2-entry {PC, Inst} queue presented to decode via valid/ready.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Inst,
    output logic [31:0] PC,
    output logic        right_valid,
    input  logic        right_ready
);

    logic [31:0] pc_req;
    logic [31:0] pc_inflight;
    logic        inflight;
    logic        kill;

    logic [31:0] q_pc   [2];
    logic [31:0] q_inst [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        pop;
    logic        push;
    logic [2:0]  occupancy;

    // Occupancy counts queued entries plus the response still in flight, so the
    // queue can never overflow when that response lands.
    always_comb begin
        right_valid    = (count != 2'd0);
        pop            = right_valid & right_ready;
        push           = inflight & ~kill & ~redirect_valid;
        occupancy      = {1'b0, count} + {2'b00, inflight};
        inst_sram_en   = reset & ~redirect_valid &
                         ((occupancy < 3'd2) | ((occupancy == 3'd2) & pop));
        inst_sram_addr = {pc_req[31:2], 2'b00};
        Inst           = right_valid ? q_inst[rd_ptr] : '0;
        PC             = right_valid ? q_pc[rd_ptr]   : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_req      <= RESET_PC;
            pc_inflight <= '0;
            inflight    <= 1'b0;
            kill        <= 1'b0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= '0;
        end else if (redirect_valid) begin
            pc_req   <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            kill     <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= '0;
        end else begin
            inflight <= inst_sram_en;
            if (inst_sram_en) begin
                pc_req      <= pc_req + 32'd4;
                pc_inflight <= pc_req;
            end
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload storage needs no reset: outputs are masked by count.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            q_pc[wr_ptr]   <= pc_inflight;
            q_inst[wr_ptr] <= inst_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            assert (count != 2'd2);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue-of-outstanding-requests reference
// model plus scenario checks for latency, stall, redirect, wrap and reset.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h1c000000;
    localparam logic [31:0] PAT = 32'h5a5a0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] Inst;
    logic [31:0] PC;
    logic        right_valid;
    logic        right_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    // Reference model: requests issued and not yet delivered or flushed, with the
    // cycle each was issued in; an entry is visible to decode two cycles later.
    logic [31:0] pend_addr [$];
    int          pend_cyc  [$];
    logic [31:0] next_addr = RPC;
    int          now = 0;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .Inst            (Inst),
        .PC              (PC),
        .right_valid     (right_valid),
        .right_ready     (right_ready)
    );

    always #5 clk = ~clk;

    // SRAM: data for a request appears next cycle; otherwise junk on the bus.
    always @(posedge clk) begin
        inst_sram_rdata <= inst_sram_en ? (inst_sram_addr ^ PAT) : $urandom();
    end

    function automatic logic m_valid();
        return (pend_addr.size() > 0) && (pend_cyc[0] + 2 <= now);
    endfunction

    function automatic logic m_en();
        logic p;
        p = m_valid() && right_ready;
        return reset && !redirect_valid &&
               (pend_addr.size() < 2 || (pend_addr.size() == 2 && p));
    endfunction

    function automatic logic [97:0] exp_vec();
        logic        v;
        logic        e;
        logic [31:0] h;
        v = m_valid();
        h = v ? pend_addr[0] : 32'h0;
        e = m_en();
        return {v, h, v ? (h ^ PAT) : 32'h0, e, e ? next_addr : 32'h0};
    endfunction

    function automatic logic [97:0] obs_vec();
        return {right_valid, PC, Inst, inst_sram_en, inst_sram_en ? inst_sram_addr : 32'h0};
    endfunction

    task automatic drive(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
        reset          = rst;
        right_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic tick();
        logic p;
        logic e;
        p = m_valid() && right_ready;
        e = m_en();
        @(posedge clk);
        if (!reset) begin
            pend_addr.delete();
            pend_cyc.delete();
            next_addr = RPC;
        end else if (redirect_valid) begin
            pend_addr.delete();
            pend_cyc.delete();
            next_addr = {redirect_pc[31:2], 2'b00};
        end else begin
            if (p) begin
                void'(pend_addr.pop_front());
                void'(pend_cyc.pop_front());
            end
            if (e) begin
                pend_addr.push_back(next_addr);
                pend_cyc.push_back(now);
                next_addr = next_addr + 32'd4;
            end
        end
        now++;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tests++;
        if (right_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid got=%b want=0", right_valid);
        end
        tests++;
        if (PC !== 32'h0) begin
            fails++;
            $display("FAIL reset_pc got=%h want=00000000", PC);
        end
        tests++;
        if (Inst !== 32'h0) begin
            fails++;
            $display("FAIL reset_inst got=%h want=00000000", Inst);
        end
        tests++;
        if (inst_sram_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_en got=%b want=0", inst_sram_en);
        end
        tick();
    endtask

    task automatic test_free_run();
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL free_run cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (c == 0) begin
                tests++;
                if ({inst_sram_en, inst_sram_addr} !== {1'b1, RPC}) begin
                    fails++;
                    $display("FAIL first_req got=%b/%h want=1/%h", inst_sram_en, inst_sram_addr, RPC);
                end
            end
            if (c >= 2) begin
                tests++;
                if ({right_valid, PC} !== {1'b1, RPC + 32'(4 * (c - 2))}) begin
                    fails++;
                    $display("FAIL free_run_pc cyc=%0d got=%b/%h want=1/%h", c, right_valid, PC,
                             RPC + 32'(4 * (c - 2)));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] h0;
        h0 = pend_addr[0];
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL bp_stall k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
            tests++;
            if ({right_valid, PC, Inst} !== {1'b1, h0, h0 ^ PAT}) begin
                fails++;
                $display("FAIL bp_hold k=%0d got=%b/%h/%h want=1/%h/%h", k, right_valid, PC, Inst, h0, h0 ^ PAT);
            end
            if (k >= 1) begin
                tests++;
                if (inst_sram_en !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_en_stop k=%0d got=%b want=0", k, inst_sram_en);
                end
            end
            tick();
        end
        for (int j = 0; j < 6; j++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL bp_resume j=%0d got=%h want=%h", j, obs_vec(), exp_vec());
            end
            tests++;
            if ({right_valid, PC} !== {1'b1, h0 + 32'(4 * j)}) begin
                fails++;
                $display("FAIL bp_seq j=%0d got=%b/%h want=1/%h", j, right_valid, PC, h0 + 32'(4 * j));
            end
            tick();
        end
    endtask

    task automatic test_redirect_inflight();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL redir_pre c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 32'h1c000103);
        tests++;
        if (inst_sram_en !== 1'b0) begin
            fails++;
            $display("FAIL redir_en_block got=%b want=0", inst_sram_en);
        end
        tick();
        for (int d = 1; d <= 4; d++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL redir_post d=%0d got=%h want=%h", d, obs_vec(), exp_vec());
            end
            if (d == 1) begin
                tests++;
                if ({inst_sram_en, inst_sram_addr} !== {1'b1, 32'h1c000100}) begin
                    fails++;
                    $display("FAIL redir_target_req got=%b/%h want=1/1c000100", inst_sram_en, inst_sram_addr);
                end
            end
            if (d < 3) begin
                tests++;
                if (right_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL redir_flush d=%0d got=%b want=0", d, right_valid);
                end
            end
            if (d == 3) begin
                tests++;
                if ({right_valid, PC, Inst} !== {1'b1, 32'h1c000100, 32'h1c000100 ^ PAT}) begin
                    fails++;
                    $display("FAIL redir_deliver got=%b/%h/%h want=1/1c000100/%h", right_valid, PC, Inst,
                             32'h1c000100 ^ PAT);
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect_pop();
        logic [31:0] t;
        logic [31:0] tgt;
        logic        seen;
        for (int it = 0; it < 4; it++) begin
            for (int c = 0; c < 3; c++) begin
                drive(1'b1, 1'b1, 1'b0, 32'h0);
                tests++;
                if (obs_vec() !== exp_vec()) begin
                    fails++;
                    $display("FAIL rpop_pre it=%0d got=%h want=%h", it, obs_vec(), exp_vec());
                end
                tick();
            end
            t    = $urandom();
            tgt  = {t[31:2], 2'b00};
            seen = 1'b0;
            drive(1'b1, 1'b1, 1'b1, t);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL rpop_cycle it=%0d got=%h want=%h", it, obs_vec(), exp_vec());
            end
            tick();
            for (int d = 1; d <= 8; d++) begin
                drive(1'b1, 1'b1, 1'b0, 32'h0);
                tests++;
                if (obs_vec() !== exp_vec()) begin
                    fails++;
                    $display("FAIL rpop_post it=%0d d=%0d got=%h want=%h", it, d, obs_vec(), exp_vec());
                end
                if (right_valid === 1'b1 && !seen) begin
                    seen = 1'b1;
                    tests++;
                    if (PC !== tgt) begin
                        fails++;
                        $display("FAIL rpop_first_pc it=%0d got=%h want=%h", it, PC, tgt);
                    end
                end
                tick();
            end
            tests++;
            if (!seen) begin
                fails++;
                $display("FAIL rpop_timeout it=%0d got=no_valid want=%h", it, tgt);
            end
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] wrap_exp [3];
        wrap_exp = '{32'hfffffff8, 32'hfffffffc, 32'h00000000};
        drive(1'b1, 1'b1, 1'b1, 32'hfffffff8);
        tick();
        for (int d = 1; d <= 6; d++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL wrap_model d=%0d got=%h want=%h", d, obs_vec(), exp_vec());
            end
            if (d >= 3 && d <= 5) begin
                tests++;
                if ({right_valid, PC} !== {1'b1, wrap_exp[d-3]}) begin
                    fails++;
                    $display("FAIL wrap_pc d=%0d got=%b/%h want=1/%h", d, right_valid, PC, wrap_exp[d-3]);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL rstm_fill c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tests++;
        if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL rstm_edge got=%h want=%h", obs_vec(), exp_vec());
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tests++;
        if (right_valid !== 1'b0) begin
            fails++;
            $display("FAIL rstm_valid got=%b want=0", right_valid);
        end
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL rstm_restart c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (c == 0) begin
                tests++;
                if ({inst_sram_en, inst_sram_addr} !== {1'b1, RPC}) begin
                    fails++;
                    $display("FAIL rstm_req got=%b/%h want=1/%h", inst_sram_en, inst_sram_addr, RPC);
                end
            end
            if (c == 2) begin
                tests++;
                if ({right_valid, PC, Inst} !== {1'b1, RPC, RPC ^ PAT}) begin
                    fails++;
                    $display("FAIL rstm_first got=%b/%h/%h want=1/%h/%h", right_valid, PC, Inst, RPC, RPC ^ PAT);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic        rst;
        logic        rv;
        logic        rdy;
        logic [31:0] rpc;
        for (int c = 0; c < 300; c++) begin
            rst = ($urandom_range(0, 49) != 0);
            rv  = ($urandom_range(0, 14) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rpc = $urandom();
            if ($urandom_range(0, 3) == 0) begin
                rpc = 32'hfffffff0 | (rpc & 32'hf);
            end
            drive(rst, rdy, rv, rpc);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_free_run();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_pop();
        test_pc_wrap();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of the decode stage. It generates the sequential PC and issues requests to a synchronous instruction SRAM with a fixed one-cycle read latency. Returned instructions are buffered with their PC in a 2-entry queue and presented to decode through the valid/ready handshake. A redirect from the back end (branch or jump resolution) discards wrong-path work and restarts fetch at the target.

## Interface
Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low (`reset == 1'b0` resets on the clock edge).
- inst_sram_en  out  1  read request this cycle.
- inst_sram_addr  out  32  request address, `{pc_req[31:2],2'b00}`.
- inst_sram_rdata  in  32  read data, valid the cycle after `inst_sram_en`.
- redirect_valid  in  1  restart fetch at `redirect_pc`.
- redirect_pc  in  32  redirect target; bits [1:0] are forced to 0.
- Inst  out  32  head-entry instruction; 0 when the queue is empty.
- PC  out  32  head-entry PC; 0 when the queue is empty.
- right_valid  out  1  queue non-empty; drives decode `left_valid`.
- right_ready  in  1  decode accepts; driven by decode `left_ready`.

## Operation
- **State**
  - `pc_req` (32): next address to request.
  - `inflight` (1): a request was issued last cycle.
  - `kill` (1): the in-flight response must be dropped.
  - 2-entry FIFO of {PC, Inst} with `rd_ptr`, `wr_ptr` (1 bit each) and `count` (0..2).
- **Pop:** `pop = right_valid & right_ready`. Head advances, `count` decrements.
- **Issue:** `inst_sram_en = reset_n & ~redirect_valid & ((count + inflight) < 2 | ((count + inflight) == 2 & pop))`.
  - On issue, `pc_req <= pc_req + 4` (mod 2^32, so 32'hfffffffc wraps to 0).
  - `inflight <= inst_sram_en`.
- **Response capture:** if `inflight & ~kill & ~redirect_valid`, write `{pc_of_inflight, inst_sram_rdata}` at `wr_ptr`.
  - `pc_of_inflight` is a register latched at issue.
  - The issue rule guarantees the queue is never full when a response arrives. A push into a full queue is an assertion failure.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance.
- **Redirect** (`redirect_valid = 1`, highest priority after reset):
  - The FIFO is cleared: `count = 0`, pointers reset to 0.
  - `pc_req <= {redirect_pc[31:2], 2'b00}`; no request is issued this cycle.
  - `kill <= 0`, and `inflight <= 0`, so any response arriving next cycle belongs to no request and is ignored.
  - Any response arriving in the redirect cycle itself is dropped.
  - Any pop in the redirect cycle is void; decode is flushed by the same event.
- **Back-to-back redirects:** the last one wins; no request is issued until the first cycle without a redirect.
- **Reset** (sync, active-low), including reset asserted mid-operation:
  - `pc_req = RESET_PC`; `inflight = 0`, `kill = 0`, `count = 0`.
  - `inst_sram_en = 0` combinationally while `reset` is low.
  - `right_valid = 0`, `Inst = 0`, `PC = 0`.
  - A response to a request issued before reset is ignored.

## Timing
- **Fetch latency:** request in cycle N, data captured at end of N+1, `right_valid` high in N+2 (2 cycles).
- **Throughput:** 1 instruction/cycle while `right_ready = 1`; steady state is `count = 1`, `inflight = 1`.
- **Stall:** when `right_ready = 0`, at most 2 requests drain into the FIFO and issue then stops. `Inst`/`PC`/`right_valid` hold stable while valid and not ready.
- **Restart after stall:** `right_ready` rising in cycle M pops in M and may issue in M; no bubble.
- **Redirect in cycle R:** first target request in R+1, target instruction valid at decode in R+3.
- **First fetch after reset release in cycle 0:** `inst_sram_en = 1` with address RESET_PC in cycle 0; `right_valid` high in cycle 2.
- Outputs `Inst`, `PC` and `right_valid` come from registers or the FIFO head only; there is no combinational path from `inst_sram_rdata` to the outputs.

## Test plan
- **Reset then free-run:** release reset, hold `right_ready = 1`, SRAM returns addr^32'h5a5a0000.
  - Expect PCs 0x1c000000, 0x1c000004, … on consecutive cycles from cycle 2.
  - Expect `Inst` to match the returned pattern.
- **Backpressure:** drop `right_ready` for 5 cycles mid-stream.
  - Exactly 2 queued entries, `inst_sram_en = 0` after the drain, head held stable.
  - On release, the sequence continues with no gap and no duplicate.
- **Redirect with a response in flight:** `redirect_valid = 1`, `redirect_pc = 0x1c000103` while `inflight = 1`.
  - The old response is dropped and the queue is emptied.
  - Next request address is 0x1c000100; valid reaches decode 3 cycles after the redirect.
- **Redirect coinciding with a pop and a response:** no wrong-path entry ever appears at `right_valid`.
  - The first delivered PC is the target.
- **PC wrap:** redirect to 0xfffffff8.
  - Delivered PCs are 0xfffffff8, 0xfffffffc, 0x00000000.
- **Reset asserted mid-stream with a full queue:** `right_valid = 0` the cycle after the reset edge.
  - After release, fetch restarts at 0x1c000000 with no stale data.
